// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel hobby-servo PWM generator, 1 us resolution.
// Frame period FRAME_US, pulse = MIN_US + clamped offset, optional per-frame slew.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command write handshake
//   cmd_ch, cmd_pos, cmd_en     target channel, position offset (us), enable
//   cmd_err                     1-cycle pulse for an out-of-range channel
//   frame_start                 1-cycle pulse at the start of each frame
//   pwm_out                     registered servo pulse outputs
module servo_pwm_multi #(
   parameter int N_CH     = 4,
   parameter int CLK_HZ   = 50_000_000,
   parameter int FRAME_US = 20000,
   parameter int MIN_US   = 1000,
   parameter int MAX_US   = 2000,
   parameter int POS_W    = 11,
   parameter int STEP_US  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_ch,
   input  logic [POS_W-1:0] cmd_pos,
   input  logic             cmd_en,
   output logic             cmd_err,
   output logic             frame_start,
   output logic [N_CH-1:0]  pwm_out
);

   localparam int DIV    = CLK_HZ / 1_000_000;
   localparam int TW     = $clog2(DIV);
   localparam int UW     = $clog2(FRAME_US);
   localparam int CENTER = (MIN_US + MAX_US) / 2;
   localparam int SPAN   = MAX_US - MIN_US;
   localparam logic [POS_W:0] SPAN_X = (POS_W+1)'(SPAN);

   logic [TW-1:0]   tick_cnt;
   logic [UW-1:0]   us_cnt;
   logic            tick;
   logic            wrap;
   logic            accept;
   logic            ch_ok;
   logic [POS_W:0]  pos_x;
   logic [POS_W:0]  pos_c;
   logic [UW-1:0]   new_tgt;
   logic [UW-1:0]   target   [N_CH];
   logic [UW-1:0]   active   [N_CH];
   logic [UW-1:0]   next_act [N_CH];
   logic [N_CH-1:0] en;
   logic [N_CH-1:0] en_act;
   logic [N_CH-1:0] pwm_d;

   assign tick    = (tick_cnt == TW'(DIV - 1));
   assign wrap    = tick && (us_cnt == UW'(FRAME_US - 1));
   assign accept  = cmd_valid & cmd_ready;
   assign ch_ok   = ({1'b0, cmd_ch} < 5'(N_CH));
   // Widened by one bit so the clamp compare cannot wrap.
   assign pos_x   = {1'b0, cmd_pos};
   assign pos_c   = (pos_x > SPAN_X) ? SPAN_X : pos_x;
   assign new_tgt = UW'(MIN_US) + UW'(pos_c);

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         next_act[i] = active[i];
         pwm_d[i]    = en_act[i] & (us_cnt < active[i]);
         if (STEP_US == 0) begin
            next_act[i] = target[i];
         end else if (target[i] > active[i]) begin
            // Step up, stopping exactly on the target.
            if (target[i] - active[i] > UW'(STEP_US))
               next_act[i] = active[i] + UW'(STEP_US);
            else
               next_act[i] = target[i];
         end else if (target[i] < active[i]) begin
            if (active[i] - target[i] > UW'(STEP_US))
               next_act[i] = active[i] - UW'(STEP_US);
            else
               next_act[i] = target[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt    <= '0;
         us_cnt      <= '0;
         frame_start <= 1'b0;
         cmd_ready   <= 1'b0;
         cmd_err     <= 1'b0;
         pwm_out     <= '0;
         en          <= '0;
         en_act      <= '0;
         for (int i = 0; i < N_CH; i++) begin
            target[i] <= UW'(CENTER);
            active[i] <= UW'(CENTER);
         end
      end else begin
         tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
         if (tick)
            us_cnt   <= wrap ? '0 : us_cnt + 1'b1;
         frame_start <= wrap;
         cmd_ready   <= 1'b1;
         cmd_err     <= accept & ~ch_ok;
         pwm_out     <= pwm_d;
         for (int i = 0; i < N_CH; i++) begin
            // Boundary update reads the pre-command target/en values.
            if (accept && ch_ok && cmd_ch == 4'(i)) begin
               target[i] <= new_tgt;
               en[i]     <= cmd_en;
            end
            if (wrap) begin
               active[i] <= next_act[i];
               en_act[i] <= en[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: two servo_pwm_multi instances (no slew / 100 us slew),
// per-frame pulse widths scored against a queue of expected widths.
module tb_servo_pwm_multi;

   logic        clk;
   logic        rst_a, rst_b;
   logic        a_valid, a_ready, a_en, a_err, a_fs;
   logic        b_valid, b_ready, b_en, b_err, b_fs;
   logic [3:0]  a_ch, b_ch;
   logic [10:0] a_pos, b_pos;
   logic [3:0]  a_pwm, b_pwm;

   typedef struct {
      int d;
      int f;
      int ch;
      int clks;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   cnt [2][4];
   int   fcnt [2];

   servo_pwm_multi #(
      .N_CH(4), .CLK_HZ(2_000_000), .FRAME_US(3000),
      .MIN_US(1000), .MAX_US(2000), .POS_W(11), .STEP_US(0)
   ) u_a (
      .clk(clk), .rst_n(rst_a),
      .cmd_valid(a_valid), .cmd_ready(a_ready),
      .cmd_ch(a_ch), .cmd_pos(a_pos), .cmd_en(a_en),
      .cmd_err(a_err), .frame_start(a_fs), .pwm_out(a_pwm)
   );

   servo_pwm_multi #(
      .N_CH(4), .CLK_HZ(2_000_000), .FRAME_US(3000),
      .MIN_US(1000), .MAX_US(2000), .POS_W(11), .STEP_US(100)
   ) u_b (
      .clk(clk), .rst_n(rst_b),
      .cmd_valid(b_valid), .cmd_ready(b_ready),
      .cmd_ch(b_ch), .cmd_pos(b_pos), .cmd_en(b_en),
      .cmd_err(b_err), .frame_start(b_fs), .pwm_out(b_pwm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic push(input int d, input int f, input int ch, input int clks);
      exp_t e;
      e.d = d; e.f = f; e.ch = ch; e.clks = clks;
      sbq.push_back(e);
   endtask

   task automatic mon(input int d, input logic r, input logic fs,
                      input logic [3:0] p);
      if (!r) begin
         for (int c = 0; c < 4; c++) cnt[d][c] = 0;
         fcnt[d] = 0;
      end else begin
         for (int c = 0; c < 4; c++) if (p[c]) cnt[d][c]++;
         if (fs) begin
            for (int i = sbq.size() - 1; i >= 0; i--) begin
               if (sbq[i].d == d && sbq[i].f == fcnt[d]) begin
                  chk($sformatf("width d%0d f%0d ch%0d", d, fcnt[d], sbq[i].ch),
                      cnt[d][sbq[i].ch], sbq[i].clks);
                  sbq.delete(i);
               end
            end
            for (int c = 0; c < 4; c++) cnt[d][c] = 0;
            fcnt[d]++;
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      mon(0, rst_a, a_fs, a_pwm);
      mon(1, rst_b, b_fs, b_pwm);
   end

   task automatic cmd(input int d, input int ch, input int pos, input bit en,
                      output logic err);
      if (d == 0) begin
         a_valid = 1'b1; a_ch = 4'(ch); a_pos = 11'(pos); a_en = en;
      end else begin
         b_valid = 1'b1; b_ch = 4'(ch); b_pos = 11'(pos); b_en = en;
      end
      @(negedge clk);
      err = (d == 0) ? a_err : b_err;
      if (d == 0) a_valid = 1'b0;
      else        b_valid = 1'b0;
   endtask

   task automatic wait_frame(input int d);
      for (int i = 0; i < 7000; i++) begin
         @(negedge clk);
         if ((d == 0) ? a_fs : b_fs) return;
      end
      chk($sformatf("fs_timeout d%0d", d), 0, 1);
   endtask

   task automatic run_a();
      logic e;
      int   t1, t2;
      for (int c = 0; c < 4; c++) push(0, 0, c, 0);
      repeat (500) @(negedge clk);
      cmd(0, 0, 500, 1'b1, e);
      chk("a_err_ok0", int'(e), 0);
      push(0, 1, 0, 3000);
      for (int c = 1; c < 4; c++) push(0, 1, c, 0);
      wait_frame(0);
      t1 = cyc;
      cmd(0, 1, 2047, 1'b1, e);
      chk("a_err_ok1", int'(e), 0);
      push(0, 2, 0, 3000);
      push(0, 2, 1, 4000);
      wait_frame(0);
      t2 = cyc;
      chk("a_period", t2 - t1, 6000);
      cmd(0, 1, 0, 1'b1, e);
      push(0, 3, 0, 3000);
      push(0, 3, 1, 2000);
      push(0, 3, 3, 0);
      wait_frame(0);
      repeat (100) @(negedge clk);
      cmd(0, 7, 0, 1'b1, e);
      chk("a_err_pulse", int'(e), 1);
      @(negedge clk);
      chk("a_err_clear", int'(a_err), 0);
      push(0, 4, 0, 3000);
      push(0, 4, 1, 2000);
      push(0, 4, 2, 0);
      push(0, 4, 3, 0);
      wait_frame(0);
      repeat (5999) @(negedge clk);
      a_valid = 1'b1; a_ch = 4'd0; a_pos = 11'd0; a_en = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      chk("a_fs_at_bnd", int'(a_fs), 1);
      push(0, 5, 0, 3000);
      push(0, 5, 1, 2000);
      push(0, 6, 0, 2000);
      push(0, 6, 1, 2000);
      push(0, 6, 3, 0);
      wait_frame(0);
      wait_frame(0);
      @(negedge clk);
   endtask

   task automatic run_b();
      logic e;
      for (int c = 0; c < 4; c++) push(1, 0, c, 0);
      repeat (300) @(negedge clk);
      cmd(1, 2, 0, 1'b1, e);
      for (int k = 1; k <= 5; k++) push(1, k, 2, (1500 - 100 * k) * 2);
      push(1, 6, 2, 2000);
      push(1, 1, 0, 0);
      push(1, 6, 3, 0);
      for (int k = 0; k < 7; k++) wait_frame(1);
      repeat (20) @(negedge clk);
      chk("b_high_pre_rst", int'(b_pwm[2]), 1);
      rst_b = 1'b0;
      @(negedge clk);
      chk("b_rst_low", int'(b_pwm), 0);
      chk("b_rst_ready", int'(b_ready), 0);
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      chk("b_ready_rel", int'(b_ready), 1);
      for (int c = 0; c < 4; c++) push(1, 0, c, 0);
      repeat (200) @(negedge clk);
      cmd(1, 3, 0, 1'b1, e);
      push(1, 1, 3, 2800);
      push(1, 1, 2, 0);
      push(1, 2, 3, 2600);
      push(1, 2, 2, 0);
      for (int k = 0; k < 3; k++) wait_frame(1);
      @(negedge clk);
   endtask

   initial begin
      repeat (95000) @(posedge clk);
      chk("watchdog", 0, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      a_valid = 1'b0; a_ch = '0; a_pos = '0; a_en = 1'b0;
      b_valid = 1'b0; b_ch = '0; b_pos = '0; b_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_a_pwm", int'(a_pwm), 0);
      chk("rst_a_ready", int'(a_ready), 0);
      chk("rst_a_fs", int'(a_fs), 0);
      chk("rst_a_err", int'(a_err), 0);
      chk("rst_b_pwm", int'(b_pwm), 0);
      chk("rst_b_ready", int'(b_ready), 0);
      rst_a = 1'b1; rst_b = 1'b1;
      @(negedge clk);
      chk("rel_a_ready", int'(a_ready), 1);
      chk("rel_b_ready", int'(b_ready), 1);
      fork
         run_a();
         run_b();
      join
      chk("sb_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
